// File: rtl/sha256_rr_scheduler.sv
// Round-robin scheduler sharing one SHA-256 compression core among NUM_REQ
// requesters. A grant is held for a whole multi-block message. Intermediate
// digests are consumed internally, and only the final digest is returned
// to the owner.
module sha256_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ-1:0]     req_first_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  input  logic [NUM_REQ*512-1:0] req_block_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [NUM_REQ-1:0]     rsp_valid_o,
  input  logic [NUM_REQ-1:0]     rsp_ready_i,
  output logic [255:0]           rsp_digest_o,
  output logic                   core_new_hash_o,
  output logic                   core_in_valid_o,
  output logic [511:0]           core_in_o,
  input  logic                   core_in_ready_i,
  input  logic                   core_out_valid_i,
  input  logic [255:0]           core_out_i,
  output logic                   core_out_ready_o,
  output logic [IDW-1:0]         grant_id_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int unsigned NR = NUM_REQ;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_RESP} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           last_q, last_d;
  logic           started_q, started_d;
  logic           err_q, err_d;

  logic           arb_hit;
  logic [IDW-1:0] arb_idx;
  int unsigned    arb_pos;

  logic           g_valid, g_first, g_last, g_rsp_ready;
  logic [511:0]   g_block;

  // Select the granted requester's inputs
  always_comb begin
    g_valid     = 1'b0;
    g_first     = 1'b0;
    g_last      = 1'b0;
    g_rsp_ready = 1'b0;
    g_block     = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      if (grant_q == IDW'(k)) begin
        g_valid     = req_valid_i[k];
        g_first     = req_first_i[k];
        g_last      = req_last_i[k];
        g_rsp_ready = rsp_ready_i[k];
        g_block     = req_block_i[k*512 +: 512];
      end
    end
  end

  // Round-robin search for a message start, beginning just after ptr_q
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    arb_pos = 0;
    for (int unsigned i = 1; i <= NR; i++) begin
      arb_pos = (32'(ptr_q) + i) % NR;
      if (!arb_hit && req_valid_i[arb_pos[IDW-1:0]] && req_first_i[arb_pos[IDW-1:0]]) begin
        arb_hit = 1'b1;
        arb_idx = arb_pos[IDW-1:0];
      end
    end
  end

  // State and context registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      ptr_q     <= IDW'(NR - 1);
      last_q    <= 1'b0;
      started_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      last_q    <= last_d;
      started_q <= started_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic; started_q marks that the message's first block is gone
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    last_d    = last_q;
    started_d = started_q;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (arb_hit) begin
          state_d   = S_SEND;
          grant_d   = arb_idx;
          ptr_d     = arb_idx;
          started_d = 1'b0;
        end
      end
      S_SEND: begin
        if (g_valid && core_in_ready_i) begin
          last_d    = g_last;
          started_d = 1'b1;
          if (started_q && g_first) err_d = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (core_out_valid_i) state_d = last_q ? S_RESP : S_SEND;
      end
      S_RESP: begin
        if (core_out_valid_i && g_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    req_ready_o      = '0;
    rsp_valid_o      = '0;
    rsp_digest_o     = '0;
    core_new_hash_o  = 1'b0;
    core_in_valid_o  = 1'b0;
    core_in_o        = '0;
    core_out_ready_o = 1'b0;
    unique case (state_q)
      S_SEND: begin
        core_in_valid_o      = g_valid;
        core_in_o            = g_block;
        core_new_hash_o      = g_first;
        req_ready_o[grant_q] = core_in_ready_i;
      end
      S_WAIT: begin
        core_out_ready_o = !last_q;
      end
      S_RESP: begin
        rsp_valid_o[grant_q] = core_out_valid_i;
        if (core_out_valid_i) rsp_digest_o = core_out_i;
        core_out_ready_o     = g_rsp_ready;
      end
      default: ;
    endcase
  end

  assign grant_id_o = grant_q;
  assign busy_o     = (state_q != S_IDLE);
  assign err_o      = err_q;

endmodule
